// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with accumulator operand source,
// status flags {N,Z,C,V} and an iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     out_r;
    logic [WIDTH-1:0]     acc_r;
    logic [3:0]           flags_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 done_r;      // product complete, waiting for output slot
    logic [SHW-1:0]       cnt_r;
    logic [2*WIDTH-1:0]   mcand_r;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier_r;    // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   prod_r;

    logic [WIDTH-1:0]     opa_s;
    logic                 out_free_s;
    logic                 accept_s;
    logic [WIDTH+3:0]     alu_s;
    logic [2*WIDTH-1:0]   prod_next_s;
    logic [2*WIDTH-1:0]   prod_fin_s;
    logic                 mul_fin_s;

    // Single-cycle operation: returns {N,Z,C,V, result}.
    function automatic logic [WIDTH+3:0] alu_calc(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic [SHW-1:0]   sh;
        ext = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                // bit WIDTH of the widened shift is the last bit pushed out
                ext = {1'b0, a} << sh;
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            OP_SHR: begin
                // bit 0 of the widened shift is the last bit pushed out
                ext = {a, 1'b0} >> sh;
                r   = ext[WIDTH:1];
                c   = ext[0];
            end
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == {WIDTH{1'b0}}), c, v, r};
    endfunction

    // Flags for a finished multiply: carry/overflow when the high half is non-zero.
    function automatic logic [3:0] mul_flags(input logic [2*WIDTH-1:0] p);
        logic hi;
        hi = |p[2*WIDTH-1:WIDTH];
        return {p[WIDTH-1], (p[WIDTH-1:0] == {WIDTH{1'b0}}), hi, hi};
    endfunction

    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready   = en && (state_r == ST_IDLE) && out_free_s;
    assign accept_s   = in_valid && in_ready;
    assign opa_s      = acc_sel ? acc_r : in_1;
    assign alu_s      = alu_calc(opcode, opa_s, in_2);

    // Next partial product and the value that completes the multiply.
    always_comb begin
        prod_next_s = prod_r;
        if (mplier_r[0]) begin
            prod_next_s = prod_r + mcand_r;
        end else begin
            prod_next_s = prod_r;
        end
        if (done_r) begin
            prod_fin_s = prod_r;
        end else begin
            prod_fin_s = prod_next_s;
        end
        mul_fin_s = en && (state_r == ST_MUL) && out_free_s
                    && (done_r || (cnt_r == CNT_LAST));
    end

    // Control FSM, multiplier datapath, output/flag/accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_r       <= '0;
            acc_r       <= '0;
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cnt_r       <= '0;
            mcand_r     <= '0;
            mplier_r    <= '0;
            prod_r      <= '0;
        end else if (en) begin
            // consumer handshake; a same-edge load below overrides this
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (opcode == OP_MUL) begin
                            state_r  <= ST_MUL;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                            cnt_r    <= '0;
                            prod_r   <= '0;
                            mcand_r  <= {{WIDTH{1'b0}}, opa_s};
                            mplier_r <= in_2;
                        end else begin
                            out_r       <= alu_s[WIDTH-1:0];
                            acc_r       <= alu_s[WIDTH-1:0];
                            flags_r     <= alu_s[WIDTH+3:WIDTH];
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (!done_r) begin
                        prod_r   <= prod_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + SHW'(1);
                        if (cnt_r == CNT_LAST) begin
                            done_r <= 1'b1;
                        end
                    end
                    if (mul_fin_s) begin
                        out_r       <= prod_fin_s[WIDTH-1:0];
                        acc_r       <= prod_fin_s[WIDTH-1:0];
                        flags_r     <= mul_flags(prod_fin_s);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_r;
    assign flags     = flags_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): vector table plus multi-cycle sequences.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic       acc_sel;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags;
    logic       busy;

    int tests;
    int fails;

    typedef struct {
        logic [2:0] op;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[18];

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .acc_sel(acc_sel), .in_1(in_1), .in_2(in_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Present an operation, wait (bounded) for in_ready, let it be accepted.
    task automatic run_op(input logic [2:0] op, input logic sel,
                          input logic [7:0] a, input logic [7:0] b);
        int n;
        opcode   = op;
        acc_sel  = sel;
        in_1     = a;
        in_2     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) begin
            chk(name, 32'(out_valid), 32'd1);
        end
    endtask

    initial begin
        int k;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 3'd0;
        acc_sel   = 1'b0;
        in_1      = 8'h00;
        in_2      = 8'h00;

        //                op     sel   a      b      out    NZCV
        vecs[0]  = '{3'd0, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0110};
        vecs[1]  = '{3'd1, 1'b0, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[2]  = '{3'd6, 1'b0, 8'h81, 8'h01, 8'h40, 4'b0010};
        vecs[3]  = '{3'd7, 1'b0, 8'h10, 8'h11, 8'h10, 4'b0011};
        vecs[4]  = '{3'd7, 1'b0, 8'h0F, 8'h03, 8'h2D, 4'b0000};
        vecs[5]  = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[6]  = '{3'd3, 1'b0, 8'h80, 8'h01, 8'h81, 4'b1000};
        vecs[7]  = '{3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1001};
        vecs[8]  = '{3'd1, 1'b0, 8'h01, 8'h02, 8'hFF, 4'b1010};
        vecs[9]  = '{3'd5, 1'b0, 8'h81, 8'h00, 8'h81, 4'b1000};
        vecs[10] = '{3'd5, 1'b0, 8'h81, 8'h01, 8'h02, 4'b0010};
        vecs[11] = '{3'd5, 1'b0, 8'h03, 8'h07, 8'h80, 4'b1010};
        vecs[12] = '{3'd4, 1'b0, 8'hAA, 8'hAA, 8'h00, 4'b0100};
        vecs[13] = '{3'd7, 1'b0, 8'hFF, 8'hFF, 8'h01, 4'b0011};
        vecs[14] = '{3'd0, 1'b0, 8'h05, 8'h03, 8'h08, 4'b0000};
        vecs[15] = '{3'd0, 1'b1, 8'hEE, 8'h02, 8'h0A, 4'b0000};
        vecs[16] = '{3'd5, 1'b1, 8'hEE, 8'h01, 8'h14, 4'b0000};
        vecs[17] = '{3'd7, 1'b1, 8'hEE, 8'h03, 8'h3C, 4'b0000};

        // reset state
        step();
        step();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // table-driven vectors, consumer always ready
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b);
            wait_valid($sformatf("vec%0d_timeout", i));
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
        end
        step();

        // MUL latency: busy and !in_ready for edges T..T+7, result at T+8
        run_op(3'd7, 1'b0, 8'h10, 8'h11);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul_busy_%0d", i), 32'({busy, in_ready, out_valid}), 32'b100);
            step();
        end
        chk("mul_done_valid", 32'({out_valid, busy}), 32'b10);
        chk("mul_done_out", 32'(out), 32'h10);
        chk("mul_done_flags", 32'(flags), 32'b0011);
        step();

        // backpressure hold, then same-edge handoff
        out_ready = 1'b0;
        run_op(3'd0, 1'b0, 8'h02, 8'h03);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_%0d", i), 32'({out_valid, in_ready, out}), 32'({1'b1, 1'b0, 8'h05}));
            step();
        end
        out_ready = 1'b1;
        opcode    = 3'd4;
        acc_sel   = 1'b0;
        in_1      = 8'hF0;
        in_2      = 8'hFF;
        in_valid  = 1'b1;
        #1;
        chk("bp_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        step();
        in_valid = 1'b0;
        chk("bp_handoff", 32'({out_valid, out, flags}), 32'({1'b1, 8'h0F, 4'b0000}));

        // en=0 blocks the handshake: out_valid and out hold
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("en_hold_%0d", i), 32'({out_valid, in_ready, out}), 32'({1'b1, 1'b0, 8'h0F}));
        end
        en = 1'b1;
        step();
        chk("en_release_drop", 32'(out_valid), 32'h0);

        // en=0 freezes the multiply counter for three edges
        run_op(3'd7, 1'b0, 8'h0F, 8'h03);
        en = 1'b0;
        step();
        step();
        step();
        chk("freeze_busy", 32'({busy, out_valid}), 32'b10);
        en = 1'b1;
        k = 3;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        chk("freeze_latency", 32'(k), 32'd11);
        chk("freeze_out", 32'(out), 32'h2D);
        step();

        // reset in the middle of a multiply
        run_op(3'd7, 1'b0, 8'h10, 8'h11);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'({out, flags, out_valid, busy}), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        run_op(3'd0, 1'b1, 8'hEE, 8'h00);
        wait_valid("midrst_acc_timeout");
        chk("midrst_acc_zero", 32'({out, flags}), 32'({8'h00, 4'b0100}));
        run_op(3'd0, 1'b0, 8'h01, 8'h01);
        wait_valid("midrst_add_timeout");
        chk("midrst_add", 32'({out, flags}), 32'({8'h02, 4'b0000}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit combinational ALU: registered, handshaked ALU of configurable width.
- Adds an accumulator operand source, a status-flag register, and an iterative multi-cycle multiplier.
- Sits between the operand-fetch logic and result writeback in the 8-bit CPU datapath.
- Uses valid/ready handshakes on both sides so the CPU sequencer can stall it.

Parameters:
- WIDTH, 8, operand/result width; power of two, 4..32.
- SHW, $clog2(WIDTH), shift-amount bits taken from in_2 (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low freezes all state.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- opcode  input  3  operation select.
- acc_sel  input  1  1: operand A = accumulator; 0: operand A = in_1.
- in_1  input  WIDTH  operand A.
- in_2  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result register.
- flags  output  4  {N,Z,C,V} registered with out.
- busy  output  1  multiply in progress.

Behaviour:
- Reset, asynchronous on rst_n low: out=0, flags=0, out_valid=0, busy=0, accumulator=0, FSM=IDLE. Any in-flight multiply is discarded.
- Opcodes:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR.
  - 101 SHL: A << in_2[SHW-1:0]. 110 SHR: logical, A >> in_2[SHW-1:0].
  - 111 MUL: low WIDTH bits of unsigned A*B.
- in_ready = en && state==IDLE && (!out_valid || out_ready).
- Accept: in_valid && in_ready at a rising edge. Operands and opcode are captured at that edge.
- Single-cycle ops: out, flags and out_valid are updated at the accept edge, so the result is visible the cycle after accept (latency 1).
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accepting opcode 111. busy=1, counter=0, product accumulator cleared.
  - MUL: shift-add one bit of B per enabled cycle. Uses a 2*WIDTH-bit internal product.
  - MUL -> IDLE when the counter reaches WIDTH-1. out, flags and out_valid load on that edge, and busy drops.
  - MUL latency: accept at edge T gives out_valid at edge T+WIDTH. in_ready stays low throughout.
- Output holding:
  - out_valid stays high and out/flags stay stable until out_valid && out_ready.
  - Handshake without a new accept: out_valid drops next edge.
  - Handshake coinciding with a new accept: out_valid stays 1 and the new result replaces the old one. There is no bubble.
  - If a MUL finishes while the previous result is unconsumed, it waits in MUL with the product held. out loads only once out_valid==0 or out_ready==1.
- Accumulator: loaded with the result every time out is loaded. Not affected by the output handshake.
- Flags:
  - N = out[WIDTH-1]; Z = (out==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: C = last bit shifted out; C=0 when shift amount is 0. V=0.
  - MUL: C = V = (upper WIDTH bits of product != 0).
- en=0: no accept and the MUL counter freezes. Outputs hold and out_valid is unchanged. A handshake with en=0 is not taken; out_valid holds.
- in_valid while in_ready=0: ignored. The source must hold its request.

Test Plan:
- WIDTH=8, ADD in_1=0xFF in_2=0x01 -> next cycle out=0x00, flags N0 Z1 C1 V0, out_valid=1.
- SUB in_1=0x80 in_2=0x01 -> out=0x7F, flags N0 Z0 C0 V1. Then SHR 0x81 by 1 -> out=0x40, C=1.
- MUL 0x10*0x11 accepted at edge T:
  - in_ready=0 and busy=1 for edges T..T+7.
  - out_valid rises at T+8 with out=0x10, C=1, V=1.
  - MUL 0x0F*0x03 -> out=0x2D, C=0, V=0.
- Backpressure: out_ready=0, accept ADD 2+3 -> out=0x05 held and in_ready=0 for 5 cycles. Raise out_ready with in_valid=1 (XOR 0xF0,0xFF) -> same-edge handoff, out=0x0F, out_valid never drops.
- Accumulator: ADD 5+3 (acc_sel=0) -> acc=8. ADD acc_sel=1 in_2=2 -> out=0x0A. SHL acc_sel=1 in_2=1 -> out=0x14.
- Reset mid-MUL: assert rst_n=0 three cycles after MUL accept -> out, flags, out_valid, busy and accumulator all 0 immediately. After release in_ready=1, and the next ADD 1+1 gives out=0x02.
